store_unit_axi: RTL
===================

// Module: store_unit_axi
// PURPOSE
//  Core-side store path: takes one SB/SH/SW/SD request from the memory stage and aligns data to an
//  AXI4-Lite write master. Emits byte strobes and splits 8-byte-boundary-crossing stores into two beats.
//  Ends every request with a one-cycle completion/fault pulse. Write-direction counterpart of the load path.
// PARAMETERS
//  XLEN      64   core register / request address+data width
//  BUS_W     64   AXI4-Lite data width; only 64 is supported (8 strobe bits)
//  AWPROT    3'b000  constant driven on awprot
// PORTS
//  clk         in   1       core clock
//  rst         in   1       asynchronous, active-low reset
//  req_valid   in   1       store request present
//  req_ready   out  1       high only in IDLE; request accepted on valid&&ready
//  req_addr    in   XLEN    byte address, any alignment
//  req_data    in   XLEN    store data, LSB-justified
//  req_size    in   2       store_size_t: 0=B 1=H 2=W 3=D
//  done_valid  out  1       one-cycle pulse: request finished
//  done_fault  out  1       valid with done_valid: some BRESP != OKAY
//  awvalid/awready/awaddr[XLEN]/awprot[3]  AXI4-Lite AW channel (master)
//  wvalid/wready/wdata[BUS_W]/wstrb[8]     AXI4-Lite W channel (master)
//  bvalid/bready/bresp[2]                  AXI4-Lite B channel (master)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; awvalid=wvalid=bready=done_valid=done_fault=0; regs cleared.
//  Align (on accept): off=addr[2:0], nbytes=1<<size; sh[127:0]=data<<(8*off);
//   mask[15:0]=((1<<nbytes)-1)<<off. Beat0: addr&~7, sh[63:0], mask[7:0].
//   Beat1 exists iff mask[15:8]!=0: (addr&~7)+8 (wraps mod 2^XLEN), sh[127:64], mask[15:8].
//   Data bits above nbytes are ignored (masked before shift).
//  FSM: IDLE -> SEND -> RESP -> (SEND2 -> RESP2) -> DONE -> IDLE.
//   IDLE: req_ready=1; on accept latch beats, assert awvalid and wvalid next cycle (enter SEND).
//   SEND/SEND2: awvalid and wvalid each held, payload stable, until its own handshake.
//     AW and W accepted independently, in either order or same cycle. Leave when both are done.
//   RESP/RESP2: bready=1; on bvalid capture bresp.
//     Beat0 bresp!=OKAY: skip beat1, go DONE with fault.
//     Else beat1 pending -> SEND2, else DONE.
//   DONE: done_valid=1 for exactly one cycle; done_fault = captured error; then IDLE.
//  Latency, zero-wait-state slave, one beat: accept@T, AW/W handshake@T+1, B@T+2, done@T+3.
//  No new request accepted until DONE; at most one outstanding AW/W/B at any time.
//  bready is never asserted outside RESP/RESP2; B before both AW/W handshakes is a protocol error.
//  Reset mid-operation: all valids drop asynchronously, transaction abandoned, no done pulse.
// STRUCTURE
//  Shared core package: store_size_t enum; AXI resp constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
//  Sub-module store_align (combinational): addr/data/size -> 2x{addr,wdata,wstrb}, two_beats.
//  The top level holds the FSM, beat registers and the error flag.
// TESTING
//  1 SB addr=0x1003 data=0xFF..AB -> awaddr=0x1000, wstrb=0x08, wdata[31:24]=0xAB, one beat.
//    done@T+3, done_fault=0.
//  2 SD addr=0x2004 data=0x66778899_017F423C:
//    beat0 0x2000, wstrb 0xF0, wdata[63:32]=0x017F423C;
//    beat1 0x2008, wstrb 0x0F, wdata[31:0]=0x66778899.
//  3 SH addr=0x3006, awready held low 3 cycles, wready immediate:
//    wvalid drops after W handshake; awvalid/awaddr stay stable; single B; wstrb=0xC0.
//  4 SW addr=0x4006, beat0 bresp=SLVERR -> no second AW/W issued.
//    done_valid one cycle with done_fault=1.
//  5 SD addr=0xFFFF_FFFF_FFFF_FFFC -> beat1 awaddr wraps to 0x0, wstrb 0x0F.
//  6 Assert rst low while in SEND -> awvalid/wvalid low same cycle; after release req_ready=1, no done.

Source files
------------

// File: rtl/store_unit_axi_pkg.sv
// store_unit_axi_pkg: shared types and constants for the core store path.
package store_unit_axi_pkg;
    localparam int XLEN = 64;
    localparam int BUS_W = 64;
    localparam logic [2:0] AWPROT = 3'b000;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } store_size_t;
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [BUS_W-1:0] data;
        logic [7:0] strb;
    } beat_t;
    function automatic logic [BUS_W-1:0] strb_to_mask(input logic [7:0] strb);
        for (int i = 0; i < 8; i++) strb_to_mask[8*i+:8] = {8{strb[i]}};
    endfunction
endpackage

// File: rtl/store_unit_axi_if.sv
// store_unit_axi_if: request/completion handshake plus AXI4-Lite write channels.
interface store_unit_axi_if;
    import store_unit_axi_pkg::*;
    logic req_valid;
    logic req_ready;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_data;
    store_size_t req_size;
    logic done_valid;
    logic done_fault;
    logic awvalid;
    logic awready;
    logic [XLEN-1:0] awaddr;
    logic [2:0] awprot;
    logic wvalid;
    logic wready;
    logic [BUS_W-1:0] wdata;
    logic [7:0] wstrb;
    logic bvalid;
    logic bready;
    logic [1:0] bresp;
    modport master (
        input req_valid, req_addr, req_data, req_size, awready, wready, bvalid, bresp,
        output req_ready, done_valid, done_fault, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready
    );
    modport slave (
        output req_valid, req_addr, req_data, req_size, awready, wready, bvalid, bresp,
        input req_ready, done_valid, done_fault, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready
    );
endinterface

// File: rtl/store_unit_axi_align.sv
// store_align: splits an unaligned store into up to two 8-byte bus beats with strobes.
module store_align
    import store_unit_axi_pkg::*;
(
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    input  store_size_t     size_i,
    output beat_t           beat0_o,
    output beat_t           beat1_o,
    output logic            two_beats_o
);
    logic [3:0] nbytes;
    logic [7:0] bmask;
    logic [127:0] sh;
    logic [15:0] mask;
    logic [XLEN-1:0] base;
    assign nbytes = 4'd1 << size_i;
    assign bmask = 8'((9'd1 << nbytes) - 9'd1);
    // Bytes above the access size are cleared before shifting so they never reach beat1.
    assign sh = {64'b0, data_i & strb_to_mask(bmask)} << {addr_i[2:0], 3'b000};
    assign mask = {8'b0, bmask} << addr_i[2:0];
    assign base = {addr_i[XLEN-1:3], 3'b000};
    assign beat0_o = '{addr: base, data: sh[63:0], strb: mask[7:0]};
    assign beat1_o = '{addr: base + XLEN'(8), data: sh[127:64], strb: mask[15:8]};
    assign two_beats_o = |mask[15:8];
endmodule

// File: rtl/store_unit_axi.sv
// store_unit_axi: store request to AXI4-Lite write master, one or two beats, single completion pulse.
module store_unit_axi
    import store_unit_axi_pkg::*;
(
    input logic clk_i,
    input logic rst_ni,
    store_unit_axi_if.master axi
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_RESP = 3'd2;
    localparam logic [2:0] S_SEND2 = 3'd3;
    localparam logic [2:0] S_RESP2 = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    logic [2:0] state_q, state_d;
    beat_t cur_q, cur_d, nxt_q, nxt_d, b0, b1;
    logic two_q, two_d, aw_q, aw_d, w_q, w_d, err_q, err_d, two, send;
    store_align u_align (
        .addr_i      (axi.req_addr),
        .data_i      (axi.req_data),
        .size_i      (axi.req_size),
        .beat0_o     (b0),
        .beat1_o     (b1),
        .two_beats_o (two)
    );
    assign send = state_q == S_SEND || state_q == S_SEND2;
    assign axi.req_ready = state_q == S_IDLE;
    assign axi.awvalid = send && !aw_q;
    assign axi.wvalid = send && !w_q;
    assign axi.awaddr = cur_q.addr;
    assign axi.awprot = AWPROT;
    assign axi.wdata = cur_q.data;
    assign axi.wstrb = cur_q.strb;
    assign axi.bready = state_q == S_RESP || state_q == S_RESP2;
    assign axi.done_valid = state_q == S_DONE;
    assign axi.done_fault = err_q;
    always_comb begin
        state_d = state_q;
        cur_d = cur_q;
        nxt_d = nxt_q;
        two_d = two_q;
        aw_d = aw_q;
        w_d = w_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: if (axi.req_valid) begin
                state_d = S_SEND;
                cur_d = b0;
                nxt_d = b1;
                two_d = two;
                err_d = 1'b0;
                aw_d = 1'b0;
                w_d = 1'b0;
            end
            S_SEND, S_SEND2: begin
                // AW and W complete independently; the beat moves on once both are in.
                aw_d = aw_q | axi.awready;
                w_d = w_q | axi.wready;
                if (aw_d && w_d) begin
                    state_d = state_q == S_SEND ? S_RESP : S_RESP2;
                    aw_d = 1'b0;
                    w_d = 1'b0;
                end
            end
            S_RESP: if (axi.bvalid) begin
                err_d = axi.bresp != RESP_OKAY;
                state_d = (err_d || !two_q) ? S_DONE : S_SEND2;
                cur_d = nxt_q;
            end
            S_RESP2: if (axi.bvalid) begin
                err_d = axi.bresp != RESP_OKAY;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cur_q <= '0;
            nxt_q <= '0;
            two_q <= 1'b0;
            aw_q <= 1'b0;
            w_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q <= cur_d;
            nxt_q <= nxt_d;
            two_q <= two_d;
            aw_q <= aw_d;
            w_q <= w_d;
            err_q <= err_d;
        end
    end
endmodule
